lsu: RTL and testbench

Load/store unit sitting directly upstream of the data memory in the cotm32 core. Accepts one load or store request at a time from the execute stage over a valid/ready handshake. Converts each request into one or two word-aligned memory accesses with byte strobes; a second access is used when the access crosses a 4-byte boundary. Returns sign- or zero-extended load data (or a fault) as a single-cycle response pulse.

---
 rtl/lsu.sv | 218 +++++++++++++++++++++
 tb/tb_lsu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit in front of the cotm32 data memory.
// Takes one load or store at a time. Splits an access that crosses a word
// boundary into two word-aligned memory cycles with byte strobes, and returns
// extended load data (or a fault) as a single-cycle response pulse.
module lsu #(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  input  logic [1:0]      i_req_size,
  input  logic            i_req_unsigned,
  output logic            o_rsp_valid,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_fault,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_wstrb,
  input  logic [XLEN-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  localparam logic [XLEN-3:0] ONE_WORD = 1;

  state_t            r_state;
  state_t            w_next;

  logic              r_we;
  logic [XLEN-1:2]   r_waddr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_unsigned;
  logic [1:0]        r_off;
  logic [2:0]        r_nbytes;
  logic [3:0]        r_mask;
  logic              r_cross;
  logic              r_fault;
  logic [31:0]       r_lo;
  logic [23:0]       r_hi;
  logic [XLEN-1:0]   r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;

  logic              w_accept;
  logic [2:0]        w_nbytes;
  logic [3:0]        w_mask;
  logic              w_misaligned;
  logic              w_fault;
  logic              w_cross;
  logic [7:0]        w_wide_mask;
  logic [63:0]       w_wide_data;
  logic [XLEN-1:0]   w_acc0_addr;
  logic [XLEN-1:0]   w_acc1_addr;
  logic [31:0]       w_aligned;
  logic [31:0]       w_load_data;

  assign w_accept    = i_req_valid && (r_state == IDLE);
  assign w_cross     = (({1'b0, i_req_addr[1:0]} + w_nbytes) > 3'd4);
  assign w_fault     = (i_req_size == 2'b11) ||
                       ((ALLOW_MISALIGNED == 1'b0) && w_misaligned);
  assign w_wide_mask = {4'b0000, r_mask} << r_off;
  assign w_wide_data = {32'h0, r_wdata} << {r_off, 3'b000};
  assign w_acc0_addr = {r_waddr, 2'b00};
  assign w_acc1_addr = {r_waddr + ONE_WORD, 2'b00};
  assign o_req_ready = (r_state == IDLE);

  // Decode access size into byte count, base mask and natural-alignment check
  always_comb begin
    w_nbytes     = 3'd4;
    w_mask       = 4'b1111;
    w_misaligned = 1'b0;
    case (i_req_size)
      2'b00: begin
        w_nbytes = 3'd1;
        w_mask   = 4'b0001;
      end
      2'b01: begin
        w_nbytes     = 3'd2;
        w_mask       = 4'b0011;
        w_misaligned = i_req_addr[0];
      end
      2'b10: begin
        w_misaligned = |i_req_addr[1:0];
      end
      default: begin
        w_nbytes = 3'd4;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: faults skip the memory cycles, crossings take two
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_fault ? DONE : ACC0;
        end
      end
      ACC0:    w_next = r_cross ? ACC1 : DONE;
      ACC1:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture the request at acceptance and load data during each access cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_unsigned <= 1'b0;
      r_off      <= 2'b00;
      r_nbytes   <= 3'd0;
      r_mask     <= 4'b0000;
      r_cross    <= 1'b0;
      r_fault    <= 1'b0;
      r_lo       <= 32'h0;
      r_hi       <= 24'h0;
    end else if (w_accept) begin
      r_we       <= i_req_we;
      r_waddr    <= i_req_addr[XLEN-1:2];
      r_wdata    <= i_req_wdata;
      r_unsigned <= i_req_unsigned;
      r_off      <= i_req_addr[1:0];
      r_nbytes   <= w_nbytes;
      r_mask     <= w_mask;
      r_cross    <= w_cross;
      r_fault    <= w_fault;
      r_lo       <= 32'h0;
      r_hi       <= 24'h0;
    end else if ((r_state == ACC0) && !r_we) begin
      r_lo <= i_mem_rdata;
    end else if ((r_state == ACC1) && !r_we) begin
      r_hi <= i_mem_rdata[23:0];
    end
  end

  // Remember the last driven memory address/data so they hold between accesses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if ((r_state == ACC0) || (r_state == ACC1)) begin
      r_mem_addr  <= o_mem_addr;
      r_mem_wdata <= o_mem_wdata;
    end
  end

  // Shift the two captured words down by the byte offset, then extend.
  // The top byte of the high word can never reach the result (at most 7 bytes span).
  always_comb begin
    w_aligned   = r_lo;
    w_load_data = 32'h0;
    case (r_off)
      2'd0:    w_aligned = r_lo;
      2'd1:    w_aligned = {r_hi[7:0],  r_lo[31:8]};
      2'd2:    w_aligned = {r_hi[15:0], r_lo[31:16]};
      default: w_aligned = {r_hi[23:0], r_lo[31:24]};
    endcase
    case (r_nbytes)
      3'd1:    w_load_data = {{24{w_aligned[7] & ~r_unsigned}},  w_aligned[7:0]};
      3'd2:    w_load_data = {{16{w_aligned[15] & ~r_unsigned}}, w_aligned[15:0]};
      default: w_load_data = w_aligned;
    endcase
  end

  // Memory-side and response-side outputs decoded from the current state
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_wstrb = 4'b0000;
    o_mem_addr  = r_mem_addr;
    o_mem_wdata = r_mem_wdata;
    o_rsp_valid = 1'b0;
    o_rsp_fault = 1'b0;
    o_rsp_rdata = '0;
    case (r_state)
      ACC0: begin
        o_mem_we    = r_we;
        o_mem_wstrb = w_wide_mask[3:0];
        o_mem_addr  = w_acc0_addr;
        o_mem_wdata = w_wide_data[31:0];
      end
      ACC1: begin
        o_mem_we    = r_we;
        o_mem_wstrb = w_wide_mask[7:4];
        o_mem_addr  = w_acc1_addr;
        o_mem_wdata = w_wide_data[63:32];
      end
      DONE: begin
        o_rsp_valid = 1'b1;
        o_rsp_fault = r_fault;
        if (!r_we && !r_fault) begin
          o_rsp_rdata = w_load_data;
        end
      end
      default: begin
        o_mem_we = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: one instance with misaligned splitting enabled,
// one with it disabled, both sharing a byte-addressed memory model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        memClear;
  logic        reqValidA, reqValidB;
  logic        reqWe;
  logic [31:0] reqAddr, reqWdata;
  logic [1:0]  reqSize;
  logic        reqUnsigned;

  logic        readyA, rspValidA, rspFaultA, memWeA;
  logic [31:0] rspRdataA, memAddrA, memWdataA, memRdataA;
  logic [3:0]  memWstrbA;
  logic        readyB, rspValidB, rspFaultB, memWeB;
  logic [31:0] rspRdataB, memAddrB, memWdataB, memRdataB;
  logic [3:0]  memWstrbB;

  logic [7:0]  mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(reqValidA), .o_req_ready(readyA),
    .i_req_we(reqWe), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .i_req_size(reqSize), .i_req_unsigned(reqUnsigned),
    .o_rsp_valid(rspValidA), .o_rsp_rdata(rspRdataA), .o_rsp_fault(rspFaultA),
    .o_mem_we(memWeA), .o_mem_addr(memAddrA), .o_mem_wdata(memWdataA),
    .o_mem_wstrb(memWstrbA), .i_mem_rdata(memRdataA)
  );

  lsu #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dutStrict (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(reqValidB), .o_req_ready(readyB),
    .i_req_we(reqWe), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .i_req_size(reqSize), .i_req_unsigned(reqUnsigned),
    .o_rsp_valid(rspValidB), .o_rsp_rdata(rspRdataB), .o_rsp_fault(rspFaultB),
    .o_mem_we(memWeB), .o_mem_addr(memAddrB), .o_mem_wdata(memWdataB),
    .o_mem_wstrb(memWstrbB), .i_mem_rdata(memRdataB)
  );

  // Combinational memory read; the low address byte selects within a 256-byte window
  assign memRdataA = {mem[{memAddrA[7:2], 2'd3}], mem[{memAddrA[7:2], 2'd2}],
                      mem[{memAddrA[7:2], 2'd1}], mem[{memAddrA[7:2], 2'd0}]};
  assign memRdataB = {mem[{memAddrB[7:2], 2'd3}], mem[{memAddrB[7:2], 2'd2}],
                      mem[{memAddrB[7:2], 2'd1}], mem[{memAddrB[7:2], 2'd0}]};

  // Byte-strobed memory writes from either instance
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (memWeA && memWstrbA[b]) mem[{memAddrA[7:2], 2'(b)}] <= memWdataA[8*b +: 8];
        if (memWeB && memWstrbB[b]) mem[{memAddrB[7:2], 2'(b)}] <= memWdataB[8*b +: 8];
      end
    end
  end

  function automatic logic [31:0] memWord(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one edge; returns #1 into the cycle after acceptance
  task automatic applyStimulus(input bit toStrict, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size,
                               input logic uns);
    reqWe       = we;
    reqAddr     = addr;
    reqWdata    = wdata;
    reqSize     = size;
    reqUnsigned = uns;
    if (toStrict) reqValidB = 1'b1;
    else          reqValidA = 1'b1;
    step();
    reqValidA = 1'b0;
    reqValidB = 1'b0;
  endtask

  initial begin
    rst = 1'b1; memClear = 1'b1;
    reqValidA = 1'b0; reqValidB = 1'b0;
    reqWe = 1'b0; reqAddr = '0; reqWdata = '0; reqSize = 2'b00; reqUnsigned = 1'b0;
    #2;
    checkOutput("rst_ready",  32'(readyA),    32'd1);
    checkOutput("rst_valid",  32'(rspValidA), 32'd0);
    checkOutput("rst_fault",  32'(rspFaultA), 32'd0);
    checkOutput("rst_rdata",  rspRdataA,      32'h0);
    checkOutput("rst_we",     32'(memWeA),    32'd0);
    checkOutput("rst_wstrb",  32'(memWstrbA), 32'h0);
    checkOutput("rst_addr",   memAddrA,       32'h0);
    checkOutput("rst_wdata",  memWdataA,      32'h0);
    @(posedge clk);
    #1;
    memClear = 1'b0;
    rst = 1'b0;

    $display("[TB] aligned word store/load");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
    checkOutput("sw_we",    32'(memWeA),    32'd1);
    checkOutput("sw_addr",  memAddrA,       32'h10);
    checkOutput("sw_wstrb", 32'(memWstrbA), 32'hF);
    checkOutput("sw_wdata", memWdataA,      32'hDEADBEEF);
    checkOutput("sw_n1_valid", 32'(rspValidA), 32'd0);
    checkOutput("sw_n1_ready", 32'(readyA),    32'd0);
    step();
    checkOutput("sw_valid", 32'(rspValidA), 32'd1);
    checkOutput("sw_fault", 32'(rspFaultA), 32'd0);
    checkOutput("sw_rdata", rspRdataA,      32'h0);
    checkOutput("sw_mem",   memWord(8'h10), 32'hDEADBEEF);
    step();
    checkOutput("sw_ready", 32'(readyA), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    checkOutput("lw_n1_valid", 32'(rspValidA), 32'd0);
    step();
    checkOutput("lw_valid", 32'(rspValidA), 32'd1);
    checkOutput("lw_rdata", rspRdataA,      32'hDEADBEEF);
    checkOutput("lw_fault", 32'(rspFaultA), 32'd0);
    step();

    $display("[TB] byte store and extension");
    applyStimulus(1'b0, 1'b1, 32'h21, 32'h00000080, 2'b00, 1'b0);
    checkOutput("sb_addr",  memAddrA,              32'h20);
    checkOutput("sb_wstrb", 32'(memWstrbA),        32'h2);
    checkOutput("sb_lane",  32'(memWdataA[15:8]),  32'h80);
    step();
    step();
    applyStimulus(1'b0, 1'b0, 32'h21, 32'h0, 2'b00, 1'b0);
    step();
    checkOutput("lb_rdata", rspRdataA, 32'hFFFFFF80);
    step();
    applyStimulus(1'b0, 1'b0, 32'h21, 32'h0, 2'b00, 1'b1);
    step();
    checkOutput("lbu_rdata", rspRdataA, 32'h00000080);
    step();
    applyStimulus(1'b0, 1'b0, 32'h12, 32'h0, 2'b01, 1'b0);
    step();
    checkOutput("lh_rdata", rspRdataA, 32'hFFFFDEAD);
    step();

    $display("[TB] crossing word store/load");
    applyStimulus(1'b0, 1'b1, 32'h0E, 32'h11223344, 2'b10, 1'b0);
    checkOutput("xsw0_addr",  memAddrA,       32'h0C);
    checkOutput("xsw0_wstrb", 32'(memWstrbA), 32'hC);
    checkOutput("xsw0_wdata", memWdataA,      32'h33440000);
    checkOutput("xsw0_we",    32'(memWeA),    32'd1);
    step();
    checkOutput("xsw1_addr",  memAddrA,       32'h10);
    checkOutput("xsw1_wstrb", 32'(memWstrbA), 32'h3);
    checkOutput("xsw1_wdata", memWdataA,      32'h00001122);
    checkOutput("xsw1_we",    32'(memWeA),    32'd1);
    checkOutput("xsw1_valid", 32'(rspValidA), 32'd0);
    step();
    checkOutput("xsw_valid", 32'(rspValidA), 32'd1);
    checkOutput("xsw_memlo", memWord(8'h0C), 32'h33440000);
    checkOutput("xsw_memhi", memWord(8'h10), 32'hDEAD1122);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0E, 32'h0, 2'b10, 1'b0);
    step();
    checkOutput("xlw_n2_valid", 32'(rspValidA), 32'd0);
    step();
    checkOutput("xlw_valid", 32'(rspValidA), 32'd1);
    checkOutput("xlw_rdata", rspRdataA,      32'h11223344);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0F, 32'h0, 2'b01, 1'b0);
    step();
    step();
    checkOutput("xlh_rdata", rspRdataA, 32'h00002233);
    step();

    $display("[TB] illegal size on permissive instance");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h12345678, 2'b11, 1'b0);
    checkOutput("sz3_valid", 32'(rspValidA), 32'd1);
    checkOutput("sz3_fault", 32'(rspFaultA), 32'd1);
    checkOutput("sz3_rdata", rspRdataA,      32'h0);
    checkOutput("sz3_we",    32'(memWeA),    32'd0);
    step();
    checkOutput("sz3_ready", 32'(readyA),    32'd1);
    checkOutput("sz3_mem",   memWord(8'h10), 32'hDEAD1122);

    $display("[TB] strict instance");
    applyStimulus(1'b1, 1'b1, 32'h03, 32'h0000BEEF, 2'b01, 1'b0);
    checkOutput("mis_valid", 32'(rspValidB), 32'd1);
    checkOutput("mis_fault", 32'(rspFaultB), 32'd1);
    checkOutput("mis_we",    32'(memWeB),    32'd0);
    step();
    checkOutput("mis_we2",   32'(memWeB),    32'd0);
    checkOutput("mis_mem0",  memWord(8'h00), 32'h0);
    checkOutput("mis_mem4",  memWord(8'h04), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    step();
    checkOutput("strict_lw_valid", 32'(rspValidB), 32'd1);
    checkOutput("strict_lw_fault", 32'(rspFaultB), 32'd0);
    checkOutput("strict_lw_rdata", rspRdataB,      32'hDEAD1122);
    step();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0);
    checkOutput("strict_sz3_fault", 32'(rspFaultB), 32'd1);
    step();

    $display("[TB] address wrap");
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFE, 32'hA1B2C3D4, 2'b10, 1'b0);
    checkOutput("wrap0_addr",  memAddrA,       32'hFFFFFFFC);
    checkOutput("wrap0_wstrb", 32'(memWstrbA), 32'hC);
    step();
    checkOutput("wrap1_addr",  memAddrA,       32'h00000000);
    checkOutput("wrap1_wstrb", 32'(memWstrbA), 32'h3);
    step();
    checkOutput("wrap_valid",  32'(rspValidA), 32'd1);
    checkOutput("wrap_mem0",   memWord(8'h00), 32'h0000A1B2);
    step();

    $display("[TB] reset during second access");
    applyStimulus(1'b0, 1'b1, 32'h1E, 32'h55667788, 2'b10, 1'b0);
    checkOutput("rmid0_addr", memAddrA, 32'h1C);
    step();
    checkOutput("rmid1_we",   32'(memWeA), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rmid_we",    32'(memWeA),    32'd0);
    checkOutput("rmid_wstrb", 32'(memWstrbA), 32'h0);
    checkOutput("rmid_addr",  memAddrA,       32'h0);
    checkOutput("rmid_wdata", memWdataA,      32'h0);
    checkOutput("rmid_valid", 32'(rspValidA), 32'd0);
    step();
    checkOutput("rmid_lo_kept",  memWord(8'h1C), 32'h77880000);
    checkOutput("rmid_hi_clean", memWord(8'h20), 32'h00008000);
    checkOutput("rmid_valid2",   32'(rspValidA), 32'd0);
    rst = 1'b0;
    step();
    checkOutput("rmid_ready", 32'(readyA),    32'd1);
    checkOutput("rmid_valid3", 32'(rspValidA), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
